// File: rtl/pe_array_ctrl_seq.sv
// Control sequencer for the PE array: LB reset, filter load, compute, drain per filter bank.
// Outputs are a pure function of registered state and latched configuration.
module pe_array_ctrl_seq #(
  parameter int N_PE      = 8,
  parameter int ADDR_FIFO = 8,
  parameter int ROWS_W    = 16,
  parameter int BANKS_W   = 8,
  parameter int PIPE_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [3:0]             filter_size,
  input  logic [ADDR_FIFO-1:0]   row_length,
  input  logic [ROWS_W-1:0]      num_rows,
  input  logic [BANKS_W-1:0]     num_banks,
  output logic                   line_buffer_reset,
  output logic [N_PE*N_PE-1:0]   shifting_filter,
  output logic [N_PE*N_PE-1:0]   shifting_line,
  output logic [N_PE*N_PE-1:0]   mac_enable,
  output logic [N_PE-1:0]        adder_enable,
  output logic [N_PE-1:0]        nl_enable,
  output logic [N_PE-1:0]        feedback_enable,
  output logic                   final_filter_bank,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {IDLE, LB_RESET, FILT_LOAD, COMPUTE, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             k_q;
  logic [ADDR_FIFO-1:0]   rl_q, col;
  logic [ROWS_W-1:0]      nr_q, row;
  logic [BANKS_W-1:0]     nb_q, bank;
  logic [7:0]             cnt;
  logic                   err_q;
  logic                   cfg_ok, filt_last, col_last, row_last, drain_last, bank_last;
  logic [N_PE*N_PE-1:0]   mask2d;
  logic [N_PE-1:0]        colmask;

  assign cfg_ok     = (filter_size != 4'd0) && (int'(filter_size) <= N_PE) &&
                      (row_length != '0) && (num_rows != '0) && (num_banks != '0);
  assign filt_last  = (int'(cnt) == int'(k_q) - 1);
  assign drain_last = (int'(cnt) == PIPE_LAT - 1);
  assign col_last   = (col == rl_q - ADDR_FIFO'(1));
  assign row_last   = (row == nr_q - ROWS_W'(1));
  assign bank_last  = (bank == nb_q - BANKS_W'(1));

  always_comb begin
    mask2d  = '0;
    colmask = '0;
    for (int i = 0; i < N_PE; i++) begin
      colmask[i] = (i < int'(k_q));
      for (int j = 0; j < N_PE; j++)
        mask2d[i*N_PE+j] = (i < int'(k_q)) && (j < int'(k_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start && cfg_ok) state_nxt = LB_RESET;
      LB_RESET:  state_nxt = FILT_LOAD;
      FILT_LOAD: if (filt_last) state_nxt = COMPUTE;
      COMPUTE:   if (col_last && row_last) state_nxt = DRAIN;
      DRAIN:     if (drain_last) state_nxt = bank_last ? DONE : LB_RESET;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Counters and configuration; the image is a nested col/row walk, never a product.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      k_q  <= '0; rl_q <= '0; nr_q <= '0; nb_q <= '0;
      col  <= '0; row  <= '0; bank <= '0; cnt  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !cfg_ok;
      case (state)
        IDLE: if (start && cfg_ok) begin
          k_q  <= filter_size;
          rl_q <= row_length;
          nr_q <= num_rows;
          nb_q <= num_banks;
          col  <= '0; row <= '0; bank <= '0; cnt <= '0;
        end
        LB_RESET: cnt <= '0;
        FILT_LOAD: begin
          if (filt_last) begin
            cnt <= '0; col <= '0; row <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        COMPUTE: begin
          cnt <= '0;
          if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + ROWS_W'(1);
          end else begin
            col <= col + ADDR_FIFO'(1);
          end
        end
        DRAIN: begin
          if (drain_last) begin
            cnt <= '0;
            if (!bank_last) bank <= bank + BANKS_W'(1);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: bank <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    line_buffer_reset = 1'b0;
    shifting_filter   = '0;
    shifting_line     = '0;
    mac_enable        = '0;
    adder_enable      = '0;
    nl_enable         = '0;
    feedback_enable   = '0;
    busy              = (state != IDLE);
    done              = (state == DONE);
    final_filter_bank = (state != IDLE) && bank_last;
    err               = err_q;
    case (state)
      LB_RESET:  line_buffer_reset = 1'b1;
      FILT_LOAD: shifting_filter = mask2d;
      COMPUTE: begin
        shifting_line = mask2d;
        mac_enable    = mask2d;
        adder_enable  = colmask;
        // Bank 0 starts a fresh sum; later banks accumulate onto it.
        if (bank != '0) feedback_enable = colmask;
      end
      DRAIN: begin
        adder_enable = colmask;
        if (bank_last) nl_enable = colmask;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_array_ctrl_seq.sv
// Scoreboard bench for pe_array_ctrl_seq with N_PE=4, PIPE_LAT=2: per-cycle expected bundle queued by stimulus.
module tb_pe_array_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [3:0]  filter_size;
  logic [7:0]  row_length;
  logic [15:0] num_rows;
  logic [7:0]  num_banks;
  logic        line_buffer_reset, final_filter_bank, busy, done, err;
  logic [15:0] shifting_filter, shifting_line, mac_enable;
  logic [3:0]  adder_enable, nl_enable, feedback_enable;

  pe_array_ctrl_seq #(.N_PE(4), .ADDR_FIFO(8), .ROWS_W(16), .BANKS_W(8), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .filter_size(filter_size), .row_length(row_length), .num_rows(num_rows), .num_banks(num_banks),
    .line_buffer_reset(line_buffer_reset), .shifting_filter(shifting_filter),
    .shifting_line(shifting_line), .mac_enable(mac_enable), .adder_enable(adder_enable),
    .nl_enable(nl_enable), .feedback_enable(feedback_enable),
    .final_filter_bank(final_filter_bank), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sc;
    logic [64:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   sc = 0;
  int   clip = 1 << 30;
  int   nvec = 0;
  int   nfail = 0;

  localparam logic [64:0] Z = '0;

  always @(posedge clk) cyc++;

  function automatic logic [64:0] pk(input logic lbr, input logic [15:0] sf, input logic [15:0] sl,
                                     input logic [15:0] mac, input logic [3:0] add, input logic [3:0] nl,
                                     input logic [3:0] fb, input logic ffb, input logic bsy,
                                     input logic dn, input logic er);
    return {lbr, sf, sl, mac, add, nl, fb, ffb, bsy, dn, er};
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      nvec++; nfail++;
      $display("FAIL sc%0d cyc%0d expectation never sampled", e.sc, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      logic [64:0] got;
      e = q.pop_front();
      got = pk(line_buffer_reset, shifting_filter, shifting_line, mac_enable, adder_enable,
               nl_enable, feedback_enable, final_filter_bank, busy, done, err);
      nvec++;
      if (got !== e.v) begin
        nfail++;
        $display("FAIL sc%0d cyc%0d bundle got %h want %h (lbr,sf,sl,mac,add,nl,fb,ffb,busy,done,err)",
                 e.sc, e.cyc - 0, got, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ex(input int c0, input int c1, input logic [64:0] v);
    for (int c = c0; c <= c1; c++)
      if (c <= clip) q.push_back('{cyc: c, sc: sc, v: v});
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 1000 && cyc < c; i++) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      nvec++; nfail++;
      $display("FAIL sc%0d drain timeout, %0d expectations left", sc, q.size());
      q.delete();
    end
    tick();
  endtask

  task automatic go(input int k, input int rl, input int nr, input int nb, output int b);
    filter_size = 4'(k); row_length = 8'(rl); num_rows = 16'(nr); num_banks = 8'(nb);
    start = 1'b1;
    b = cyc;
  endtask

  // k=3, row_length=5, num_rows=2, one bank
  task automatic exp_s1(input int b);
    ex(b,      b,      Z);
    ex(b + 1,  b + 1,  pk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    ex(b + 2,  b + 4,  pk(0, 16'h0777, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    ex(b + 5,  b + 14, pk(0, 0, 16'h0777, 16'h0777, 4'h7, 0, 0, 1, 1, 0, 0));
    ex(b + 15, b + 16, pk(0, 0, 0, 0, 4'h7, 4'h7, 0, 1, 1, 0, 0));
    ex(b + 17, b + 17, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    ex(b + 18, b + 18, Z);
  endtask

  task automatic illegal(input int k, input int rl, input int nr, input int nb);
    int b;
    sc++;
    go(k, rl, nr, nb, b);
    ex(b, b, Z);
    ex(b + 1, b + 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    ex(b + 2, b + 3, Z);
    tick(); start = 1'b0;
    drain();
  endtask

  task automatic interrupt(input bit use_rst);
    int b;
    sc++;
    go(3, 5, 2, 1, b);
    clip = b + 8;
    exp_s1(b);
    clip = 1 << 30;
    ex(b + 9, b + 9, Z);
    tick(); start = 1'b0;
    wait_until(b + 8);
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0;
    wait_until(b + 10);
    go(3, 5, 2, 1, b);
    exp_s1(b);
    tick(); start = 1'b0;
    drain();
  endtask

  initial begin
    int b;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    filter_size = '0; row_length = '0; num_rows = '0; num_banks = '0;
    tick(); tick();
    ex(cyc, cyc + 1, Z);
    tick();
    rst = 1'b0;
    drain();

    // single bank
    sc = 1;
    go(3, 5, 2, 1, b);
    exp_s1(b);
    tick(); start = 1'b0;
    drain();

    // two banks: feedback in bank 1, nl only in the final bank
    sc = 2;
    go(3, 5, 2, 2, b);
    ex(b,      b,      Z);
    ex(b + 1,  b + 1,  pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    ex(b + 2,  b + 4,  pk(0, 16'h0777, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    ex(b + 5,  b + 14, pk(0, 0, 16'h0777, 16'h0777, 4'h7, 0, 0, 0, 1, 0, 0));
    ex(b + 15, b + 16, pk(0, 0, 0, 0, 4'h7, 0, 0, 0, 1, 0, 0));
    ex(b + 17, b + 17, pk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    ex(b + 18, b + 20, pk(0, 16'h0777, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    ex(b + 21, b + 30, pk(0, 0, 16'h0777, 16'h0777, 4'h7, 0, 4'h7, 1, 1, 0, 0));
    ex(b + 31, b + 32, pk(0, 0, 0, 0, 4'h7, 4'h7, 0, 1, 1, 0, 0));
    ex(b + 33, b + 33, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    ex(b + 34, b + 34, Z);
    tick(); start = 1'b0;
    drain();

    // full array, minimal image
    sc = 3;
    go(4, 1, 1, 1, b);
    ex(b,     b,     Z);
    ex(b + 1, b + 1, pk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    ex(b + 2, b + 5, pk(0, 16'hFFFF, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    ex(b + 6, b + 6, pk(0, 0, 16'hFFFF, 16'hFFFF, 4'hF, 0, 0, 1, 1, 0, 0));
    ex(b + 7, b + 8, pk(0, 0, 0, 0, 4'hF, 4'hF, 0, 1, 1, 0, 0));
    ex(b + 9, b + 9, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    ex(b + 10, b + 10, Z);
    tick(); start = 1'b0;
    drain();

    sc = 3;
    illegal(0, 5, 2, 1);
    illegal(5, 5, 2, 1);
    illegal(3, 0, 2, 1);
    illegal(3, 5, 0, 1);
    illegal(3, 5, 2, 0);

    interrupt(1'b0);
    interrupt(1'b1);

    // start during COMPUTE with different inputs must be ignored
    sc++;
    go(3, 5, 2, 1, b);
    exp_s1(b);
    tick(); start = 1'b0;
    wait_until(b + 6);
    filter_size = 4'd2; row_length = 8'd1; num_rows = 16'd1; num_banks = 8'd3;
    start = 1'b1;
    tick(); start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
